// File: rtl/seq_div.sv
// Sequential restoring signed divider: one quotient bit per cycle, fixed
// NBITS+1 cycle latency, start/busy/done handshake, divide-by-zero and overflow flags.
module seq_div #(
  parameter int NBITS     = 16,
  parameter int COUNTBITS = 5
) (
  input  logic             wClk,
  input  logic             nRst,
  input  logic             start,
  input  logic [NBITS-1:0] xDvd,
  input  logic [NBITS-1:0] xDvs,
  output logic [NBITS-1:0] xQuot,
  output logic [NBITS-1:0] xRem,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic             ovf
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  localparam logic [NBITS-1:0]     ONE   = NBITS'(1);
  localparam logic [NBITS-1:0]     Q_MAX = {1'b0, {(NBITS-1){1'b1}}};
  localparam logic [NBITS-1:0]     Q_MIN = {1'b1, {(NBITS-1){1'b0}}};
  localparam logic [COUNTBITS-1:0] LAST  = COUNTBITS'(NBITS);

  state_t               state_q;
  logic [COUNTBITS-1:0] count_q;
  logic [NBITS-1:0]     dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [NBITS-1:0]     dvs_q;
  logic [NBITS:0]       rem_q;
  logic                 sd_q, sv_q;
  logic [NBITS-1:0]     quot_q, rout_q;
  logic                 busy_q, done_q, dz_q, ovf_q;

  logic [NBITS-1:0] abs_dvd, abs_dvs;
  logic [NBITS:0]   rem_shift, rem_d;
  logic [NBITS+1:0] trial;
  logic             q_bit;
  logic [NBITS-1:0] dvd_d;
  logic [NBITS-1:0] qmag, rmag, qneg, rneg;
  logic [NBITS-1:0] res_quot, res_rem;
  logic             res_dz, res_ovf;

  assign abs_dvd = xDvd[NBITS-1] ? (~xDvd + ONE) : xDvd;
  assign abs_dvs = xDvs[NBITS-1] ? (~xDvs + ONE) : xDvs;

  assign rem_shift = {rem_q[NBITS-1:0], dvd_q[NBITS-1]};
  assign trial     = {1'b0, rem_shift} - {2'b00, dvs_q};
  assign q_bit     = ~trial[NBITS+1];
  assign rem_d     = q_bit ? trial[NBITS:0] : rem_shift;
  assign dvd_d     = {dvd_q[NBITS-2:0], q_bit};

  assign qmag = dvd_q;
  assign rmag = rem_q[NBITS-1:0];
  assign qneg = ~qmag + ONE;
  assign rneg = ~rmag + ONE;

  // Only |-2^(N-1)| / 1 with equal signs can yield a magnitude with the top bit set.
  always_comb begin
    res_quot = (sd_q ^ sv_q) ? qneg : qmag;
    res_rem  = sd_q ? rneg : rmag;
    res_dz   = 1'b0;
    res_ovf  = 1'b0;
    if (dvs_q == '0) begin
      res_dz   = 1'b1;
      res_quot = sd_q ? Q_MIN : Q_MAX;
    end else if (!(sd_q ^ sv_q) && qmag[NBITS-1]) begin
      res_ovf  = 1'b1;
      res_quot = Q_MAX;
      res_rem  = '0;
    end
  end

  always_ff @(posedge wClk or negedge nRst) begin
    if (!nRst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      sd_q    <= 1'b0;
      sv_q    <= 1'b0;
      quot_q  <= '0;
      rout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        state_q <= S_RUN;
        busy_q  <= 1'b1;
        count_q <= '0;
        dvd_q   <= abs_dvd;
        dvs_q   <= abs_dvs;
        sd_q    <= xDvd[NBITS-1];
        sv_q    <= xDvs[NBITS-1];
        rem_q   <= '0;
      end else if (state_q == S_RUN) begin
        if (count_q == LAST) begin
          quot_q  <= res_quot;
          rout_q  <= res_rem;
          dz_q    <= res_dz;
          ovf_q   <= res_ovf;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_IDLE;
        end else begin
          rem_q   <= rem_d;
          dvd_q   <= dvd_d;
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  assign xQuot = quot_q;
  assign xRem  = rout_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign dz    = dz_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_seq_div.sv
// Scoreboard bench for seq_div: driver pushes model results, monitor pops on done.
module tb_seq_div;

  logic        wClk = 1'b0;
  logic        nRst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] xDvd = '0, xDvs = '0;
  logic [15:0] xQuot, xRem;
  logic        busy, done, dz, ovf;

  seq_div #(.NBITS(16), .COUNTBITS(5)) dut (
    .wClk(wClk), .nRst(nRst), .start(start), .xDvd(xDvd), .xDvs(xDvs),
    .xQuot(xQuot), .xRem(xRem), .busy(busy), .done(done), .dz(dz), .ovf(ovf)
  );

  always #5 wClk = ~wClk;

  typedef struct {
    logic [15:0] a, b, q, r;
    logic        dz, ovf;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] last_q = '0, last_r = '0;
  logic [1:0]  last_f = '0;

  always @(posedge wClk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  // Reference model: plain integer division truncating toward zero.
  function automatic exp_t model(logic [15:0] a, logic [15:0] b);
    exp_t e;
    int   ia, ib;
    ia = $signed(a);
    ib = $signed(b);
    e.a = a; e.b = b; e.dz = 1'b0; e.ovf = 1'b0; e.due = 0;
    if (ib == 0) begin
      e.q  = (ia >= 0) ? 16'h7FFF : 16'h8000;
      e.r  = a;
      e.dz = 1'b1;
    end else if (ia == -32768 && ib == -1) begin
      e.q   = 16'h7FFF;
      e.r   = 16'h0000;
      e.ovf = 1'b1;
    end else begin
      e.q = 16'(ia / ib);
      e.r = 16'(ia % ib);
    end
    return e;
  endfunction

  always @(negedge wClk) begin
    exp_t e;
    if (done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        e = sb.pop_front();
        $display("txn %h / %h -> quot=%h rem=%h dz=%b ovf=%b at cyc %0d",
                 e.a, e.b, xQuot, xRem, dz, ovf, cyc);
        chk("quot", 32'(xQuot), 32'(e.q));
        chk("rem", 32'(xRem), 32'(e.r));
        chk("dz", 32'(dz), 32'(e.dz));
        chk("ovf", 32'(ovf), 32'(e.ovf));
        chk("latency", 32'(cyc), 32'(e.due));
        chk("busy_at_done", 32'(busy), 32'd0);
        last_q = e.q;
        last_r = e.r;
        last_f = {e.dz, e.ovf};
      end
    end else begin
      chk("busy", 32'(busy), 32'(sb.size() != 0));
      chk("hold_quot", 32'(xQuot), 32'(last_q));
      chk("hold_rem", 32'(xRem), 32'(last_r));
      chk("hold_flags", 32'({dz, ovf}), 32'(last_f));
    end
  end

  // Called just after a rising edge; the start edge is the next rising edge.
  task automatic do_start(logic [15:0] a, logic [15:0] b);
    exp_t e;
    #1;
    xDvd  = a;
    xDvs  = b;
    start = 1'b1;
    @(posedge wClk);
    #1;
    start = 1'b0;
    sb.delete();
    e     = model(a, b);
    e.due = cyc + 17;
    sb.push_back(e);
    xDvd  = 16'($urandom);
    xDvs  = 16'($urandom);
  endtask

  task automatic wait_cycles(int n);
    repeat (n) @(posedge wClk);
    #1;
  endtask

  task automatic pulse_reset(int n);
    #1;
    nRst = 1'b0;
    sb.delete();
    last_q = '0;
    last_r = '0;
    last_f = '0;
    repeat (n) @(posedge wClk);
    #1;
    nRst = 1'b1;
  endtask

  initial begin
    logic [15:0] a, b;
    int          gap;
    #23;
    nRst = 1'b1;
    wait_cycles(3);

    do_start(16'd100, 16'd7);            wait_cycles(20);
    do_start(-16'sd100, 16'd7);          wait_cycles(20);
    do_start(16'd100, -16'sd7);          wait_cycles(20);
    do_start(16'h8000, 16'hFFFF);        wait_cycles(20);
    do_start(16'h8000, 16'h0001);        wait_cycles(20);
    do_start(16'd5, 16'd0);              wait_cycles(20);
    do_start(-16'sd5, 16'd0);            wait_cycles(20);
    do_start(16'h8000, 16'h0000);        wait_cycles(20);
    do_start(16'h7FFF, 16'h8000);        wait_cycles(20);

    // Restart while busy: only the second operation may complete.
    do_start(16'd100, 16'd7);            wait_cycles(7);
    do_start(16'd9, 16'd2);              wait_cycles(20);

    // Start on the completion edge: aborted result never appears.
    do_start(16'd1000, 16'd3);           wait_cycles(16);
    do_start(-16'sd1234, 16'd10);        wait_cycles(20);

    // Reset mid-operation.
    do_start(16'd100, 16'd7);            wait_cycles(4);
    pulse_reset(2);
    wait_cycles(25);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 7))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: a = 16'h8000;
        3: b = 16'($urandom_range(1, 9));
        default: ;
      endcase
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 17)) : 18;
      do_start(a, b);
      wait_cycles(gap);
    end

    for (int t = 0; t < 40 && sb.size() != 0; t++) wait_cycles(1);
    chk("drain_timeout", 32'(sb.size()), 32'd0);
    wait_cycles(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=running required=finished cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
